// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: resolves data-mem wait, MUL/DIV occupancy,
// branch redirect, load-use and fetch wait into per-register HOLD/FLUSH controls plus a stall counter.
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1_ADDR,
    input  logic [4:0]  ID_RS2_ADDR,
    input  logic        EX_MEM_READ,
    input  logic [4:0]  EX_REG_WRITE_ADDR,
    input  logic        EX_BRANCH_TAKEN,
    input  logic        EX_MULDIV_START,
    input  logic        EX_IS_DIV,
    input  logic        INST_MEM_BUSYWAIT,
    input  logic        DATA_MEM_BUSYWAIT,
    output logic        PC_HOLD,
    output logic        IF_ID_HOLD,
    output logic        ID_EX_HOLD,
    output logic        EX_MEM_HOLD,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        EX_MEM_FLUSH,
    output logic        MEM_WB_FLUSH,
    output logic        MULDIV_BUSY,
    output logic        MULDIV_DONE,
    output logic [31:0] STALL_CYCLES
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MULDIV = 1'b1
    } state_t;

    localparam logic [5:0] MUL_LAT = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LAT = 6'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic [5:0]  lat;
    logic        load_use;
    logic        m_stall;

    logic        pc_hold;
    logic        if_id_hold;
    logic        id_ex_hold;
    logic        ex_mem_hold;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        muldiv_busy;
    logic        muldiv_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign lat      = EX_IS_DIV ? DIV_LAT : MUL_LAT;
    assign load_use = EX_MEM_READ && (EX_REG_WRITE_ADDR != 5'd0) &&
                      ((EX_REG_WRITE_ADDR == ID_RS1_ADDR) || (EX_REG_WRITE_ADDR == ID_RS2_ADDR));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        m_stall      = 1'b0;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        muldiv_busy  = 1'b0;
        muldiv_done  = 1'b0;

        if (!RESET) begin
            muldiv_busy = (state_q == ST_MULDIV);

            if (DATA_MEM_BUSYWAIT) begin
                // Whole front of the pipe freezes; the MEM result is not ready so WB gets a bubble.
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_hold   = 1'b1;
                ex_mem_hold  = 1'b1;
                mem_wb_flush = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (EX_MULDIV_START) begin
                            if (lat > 6'd1) begin
                                m_stall = 1'b1;
                                state_d = ST_MULDIV;
                                cnt_d   = lat - 6'd2;
                            end else begin
                                muldiv_done = 1'b1;
                            end
                        end
                    end
                    ST_MULDIV: begin
                        if (cnt_q != 6'd0) begin
                            m_stall = 1'b1;
                            cnt_d   = cnt_q - 6'd1;
                        end else begin
                            muldiv_done = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = 6'd0;
                    end
                endcase

                if (m_stall) begin
                    pc_hold      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_flush = 1'b1;
                end else begin
                    // A taken branch discards the wrong-path fetch, so the target must load even if
                    // fetch or a load-use would otherwise hold; load-use keeps IF/ID over a fetch bubble.
                    pc_hold     = (load_use || INST_MEM_BUSYWAIT) && !EX_BRANCH_TAKEN;
                    if_id_hold  = load_use && !EX_BRANCH_TAKEN;
                    if_id_flush = EX_BRANCH_TAKEN || (INST_MEM_BUSYWAIT && !load_use);
                    id_ex_flush = EX_BRANCH_TAKEN || load_use;
                end
            end
        end

        stall_cnt_d = stall_cnt_q + 32'(pc_hold);
    end

    assign PC_HOLD      = pc_hold;
    assign IF_ID_HOLD   = if_id_hold;
    assign ID_EX_HOLD   = id_ex_hold;
    assign EX_MEM_HOLD  = ex_mem_hold;
    assign IF_ID_FLUSH  = if_id_flush;
    assign ID_EX_FLUSH  = id_ex_flush;
    assign EX_MEM_FLUSH = ex_mem_flush;
    assign MEM_WB_FLUSH = mem_wb_flush;
    assign MULDIV_BUSY  = muldiv_busy;
    assign MULDIV_DONE  = muldiv_done;
    assign STALL_CYCLES = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected control vectors are queued as each cycle's
// stimulus is driven and compared against the DUT on the following falling edge.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  rs1, rs2, rd;
    logic        mem_read, br_taken, md_start, is_div, imem_busy, dmem_busy;
    logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        md_busy, md_done;
    logic [31:0] stall_cycles;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(33)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .ID_RS1_ADDR       (rs1),
        .ID_RS2_ADDR       (rs2),
        .EX_MEM_READ       (mem_read),
        .EX_REG_WRITE_ADDR (rd),
        .EX_BRANCH_TAKEN   (br_taken),
        .EX_MULDIV_START   (md_start),
        .EX_IS_DIV         (is_div),
        .INST_MEM_BUSYWAIT (imem_busy),
        .DATA_MEM_BUSYWAIT (dmem_busy),
        .PC_HOLD           (pc_hold),
        .IF_ID_HOLD        (if_id_hold),
        .ID_EX_HOLD        (id_ex_hold),
        .EX_MEM_HOLD       (ex_mem_hold),
        .IF_ID_FLUSH       (if_id_flush),
        .ID_EX_FLUSH       (id_ex_flush),
        .EX_MEM_FLUSH      (ex_mem_flush),
        .MEM_WB_FLUSH      (mem_wb_flush),
        .MULDIV_BUSY       (md_busy),
        .MULDIV_DONE       (md_done),
        .STALL_CYCLES      (stall_cycles)
    );

    localparam logic [9:0] PCH = 10'b10_0000_0000;
    localparam logic [9:0] IFH = 10'b01_0000_0000;
    localparam logic [9:0] IDH = 10'b00_1000_0000;
    localparam logic [9:0] EXH = 10'b00_0100_0000;
    localparam logic [9:0] IFF = 10'b00_0010_0000;
    localparam logic [9:0] IDF = 10'b00_0001_0000;
    localparam logic [9:0] EXF = 10'b00_0000_1000;
    localparam logic [9:0] MWF = 10'b00_0000_0100;
    localparam logic [9:0] BSY = 10'b00_0000_0010;
    localparam logic [9:0] DON = 10'b00_0000_0001;
    localparam logic [9:0] M_STALL = PCH | IFH | IDH | EXF;
    localparam logic [9:0] D_WAIT  = PCH | IFH | IDH | EXH | MWF;

    logic [9:0]  ctrl_act;
    assign ctrl_act = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush,
                       id_ex_flush, ex_mem_flush, mem_wb_flush, md_busy, md_done};

    logic [9:0]  exp_q[$];
    logic [31:0] exp_stall;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        mem_read = 1'b0; br_taken = 1'b0; md_start = 1'b0; is_div = 1'b0;
        imem_busy = 1'b0; dmem_busy = 1'b0;
    endtask

    // Inputs for the cycle are already driven; queue its expectation, check mid-cycle, advance.
    task automatic step(input logic [9:0] e, input string tag);
        logic [9:0] got;
        exp_q.push_back(e);
        @(negedge CLK);
        got = exp_q.pop_front();
        chk(tag, {22'd0, ctrl_act}, {22'd0, got});
        chk({tag, "_stall"}, stall_cycles, exp_stall);
        if (RESET)
            exp_stall = 32'd0;
        else if (got[9])
            exp_stall = exp_stall + 32'd1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // T1: reset with every input asserted
        RESET = 1'b1;
        rs1 = 5'h1F; rs2 = 5'h1F; rd = 5'h1F;
        mem_read = 1'b1; br_taken = 1'b1; md_start = 1'b1; is_div = 1'b1;
        imem_busy = 1'b1; dmem_busy = 1'b1;
        exp_stall = 32'd0;
        @(posedge CLK);
        #1;
        step(10'd0, "rst_a");
        step(10'd0, "rst_b");
        RESET = 1'b0;
        clear_inputs();
        step(10'd0, "idle");

        // T2: load-use on rs2, one bubble, then rd=x0 and rs1 match
        mem_read = 1'b1; rd = 5'd5; rs2 = 5'd5;
        step(PCH | IFH | IDF, "lu_rs2");
        clear_inputs();
        step(10'd0, "lu_after");
        mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        step(10'd0, "lu_x0");
        mem_read = 1'b1; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd3;
        step(PCH | IFH | IDF, "lu_rs1");
        rd = 5'd9;
        step(10'd0, "lu_nomatch");
        clear_inputs();

        // T3: DIV occupies EX 33 cycles, MUL 2 cycles
        md_start = 1'b1; is_div = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (c == 1)       step(M_STALL, "div_first");
            else if (c == 33) step(BSY | DON, "div_done");
            else              step(M_STALL | BSY, "div_stall");
        end
        clear_inputs();
        step(10'd0, "div_idle");
        md_start = 1'b1; is_div = 1'b0;
        step(M_STALL, "mul_stall");
        step(BSY | DON, "mul_done");
        clear_inputs();
        step(10'd0, "mul_idle");

        // T4: data-mem wait for 3 cycles while the DIV counter is at 10
        md_start = 1'b1; is_div = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            dmem_busy = (c >= 23 && c <= 25);
            if (c == 1)            step(M_STALL, "dw_first");
            else if (dmem_busy)    step(D_WAIT | BSY, "dw_freeze");
            else if (c == 36)      step(BSY | DON, "dw_done");
            else                   step(M_STALL | BSY, "dw_stall");
        end
        clear_inputs();
        step(10'd0, "dw_idle");

        // T5: branch dominates load-use and fetch wait; lower-rule combinations
        br_taken = 1'b1; mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; imem_busy = 1'b1;
        step(IFF | IDF, "br_all");
        imem_busy = 1'b0;
        step(IFF | IDF, "br_lu");
        clear_inputs();
        imem_busy = 1'b1;
        step(PCH | IFF, "imem");
        mem_read = 1'b1; rd = 5'd4; rs2 = 5'd4;
        step(PCH | IFH | IDF, "lu_imem");
        clear_inputs();
        br_taken = 1'b1; dmem_busy = 1'b1;
        step(D_WAIT, "dw_br");
        clear_inputs();

        // T6: reset aborts a DIV at CNT=5, then counter wrap
        md_start = 1'b1; is_div = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            if (c == 1) step(M_STALL, "ab_first");
            else        step(M_STALL | BSY, "ab_stall");
        end
        RESET = 1'b1;
        step(10'd0, "ab_reset");
        RESET = 1'b0;
        clear_inputs();
        step(10'd0, "ab_after");
        step(10'd0, "ab_after2");

        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        exp_stall = 32'hFFFF_FFFF;
        imem_busy = 1'b1;
        step(PCH | IFF, "wrap_hold");
        clear_inputs();
        step(10'd0, "wrap_zero");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
